seg_scan_counter: RTL

//   Parametrised successor to the lab3 display top: an N-digit hex up/down counter with multiplexed seven-segment drive.

---
 rtl/seg_scan_if.sv | 23 ++
 rtl/seg_scan_counter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Control and display bundle between a board-level driver and seg_scan_counter.
// The master drives the count controls; the slave (counter) drives the display and taps.
interface seg_scan_if #(
    parameter int N_DIGITS = 8
);
    logic                    top_en;
    logic                    top_sel;
    logic                    top_clr;
    logic [6:0]              top_cc;
    logic [N_DIGITS-1:0]     top_an;
    logic [4*N_DIGITS-1:0]   top_value;
    logic                    top_tick;

    modport master (
        output top_en, top_sel, top_clr,
        input  top_cc, top_an, top_value, top_tick
    );

    modport slave (
        input  top_en, top_sel, top_clr,
        output top_cc, top_an, top_value, top_tick
    );
endinterface

// File: rtl/seg_scan_counter.sv
// N-digit hex up/down counter with multiplexed, registered seven-segment drive.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module seg_scan_counter #(
    parameter int N_DIGITS    = 8,
    parameter int COUNT_DIV   = 100000,
    parameter int REFRESH_DIV = 1000
) (
    input  logic     sys_clk,
    input  logic     top_rst_n,
    seg_scan_if.slave bus
);
    localparam int VW = 4 * N_DIGITS;
    localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] COUNT_LAST   = CW'(COUNT_DIV - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] DIGIT_LAST   = IW'(N_DIGITS - 1);

    logic [CW-1:0]       cnt_pre;
    logic [VW-1:0]       value;
    logic                tick;
    logic [RW-1:0]       ref_pre;
    logic [IW-1:0]       idx;
    logic [6:0]          cc;
    logic [N_DIGITS-1:0] an;
    logic [3:0]          nibble;
    logic                blank;
    logic                step;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    assign step = bus.top_en && (cnt_pre == COUNT_LAST);

    // Clear wins over a coincident step, so the tick is suppressed with it.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            cnt_pre <= '0;
            value   <= '0;
            tick    <= 1'b0;
        end else if (bus.top_clr) begin
            cnt_pre <= '0;
            value   <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= step;
            if (bus.top_en) cnt_pre <= step ? '0 : cnt_pre + CW'(1);
            if (step) value <= bus.top_sel ? value - VW'(1) : value + VW'(1);
        end
    end

    // Scan timing is independent of counting and of clear.
    always_ff @(posedge sys_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            ref_pre <= '0;
            idx     <= '0;
        end else if (ref_pre == REFRESH_LAST) begin
            ref_pre <= '0;
            idx     <= (idx == DIGIT_LAST) ? '0 : idx + IW'(1);
        end else begin
            ref_pre <= ref_pre + RW'(1);
        end
    end

    assign nibble = value[4*int'(idx) +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [IW-1:0] msd;

    // NOTE: msd gets a default before the loop so this block can never infer a latch.
    always_comb begin
        msd = '0;
        for (int i = 1; i < N_DIGITS; i++) begin
            if (value[4*i +: 4] != 4'h0) msd = IW'(i);
        end
    end

    assign blank = (idx > msd);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            an <= '1;
            cc <= 7'h7F;
        end else if (blank) begin
            an <= '1;
            cc <= 7'h7F;
        end else begin
            an <= ~(N_DIGITS'(1) << idx);
            cc <= glyph(nibble);
        end
    end

    assign bus.top_cc    = cc;
    assign bus.top_an    = an;
    assign bus.top_value = value;
    assign bus.top_tick  = tick;
endmodule
